yarvi_trace_tx: RTL and testbench
=================================

Name: yarvi_trace_tx

Overview:
- Producer side of the retired-instruction trace interface.
- Captures each commit record (prv, pc, insn, optional writeback) from the core's retire stage.
- Buffers records in a small FIFO and serializes them as a framed little-endian byte stream over a valid/ready byte channel (UART bridge or debug DMA).
- The core cannot stall: records arriving while the FIFO is full are dropped, counted and flagged in the stream.

Parameters:
- DEPTH, 4, FIFO depth in records; power of two, minimum 2.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- valid  in  1  commit record present this cycle
- prv  in  2  privilege level of retired insn
- pc  in  32  pc of retired insn
- insn  in  32  retired instruction word
- we  in  1  retired insn writes rd
- addr  in  5  rd index (meaningful when we)
- d  in  32  rd write data (meaningful when we)
- tx_data  out  8  stream byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  sink accepts byte
- overflow  out  1  sticky: at least one record dropped since reset
- dropped_count  out  16  records dropped since reset, saturating at 0xFFFF

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset).
- Reset values: tx_valid=0, tx_data=0, overflow=0, dropped_count=0, FIFO empty, FSM IDLE, pending-drop flag=0.
- Push:
  - valid & !full pushes {drop_pending, prv, pc, insn, we, addr, d} (105 bits) and clears drop_pending.
  - valid & full drops the record, sets drop_pending and overflow, and increments dropped_count (saturating).
  - full is computed from the registered occupancy only. A push at full is dropped even if a pop occurs in the same cycle.
  - valid=0 never changes FIFO state.
- Frame format, bytes in order:
  - HDR = {4'hA, we, drop, prv[1:0]}
  - PC0..PC3 (LSB first)
  - IN0..IN3 (LSB first)
  - if we: RD = {3'b0, addr}, then D0..D3 (LSB first)
  - Frame length is 9 bytes (we=0) or 14 bytes (we=1).
- FSM states and transitions:
  - IDLE -> HDR when FIFO non-empty.
  - HDR -> PC on handshake.
  - PC -> INSN after 4 handshakes.
  - INSN -> RD after 4 handshakes if we, else frame end.
  - RD -> DATA on handshake.
  - DATA -> frame end after 4 handshakes.
  - A 2-bit byte counter sequences the multi-byte states.
  - At frame end the FIFO pops on the same cycle as the final handshake. If the FIFO is still non-empty, go directly to HDR of the next record; otherwise go to IDLE.
- Serializer reads the FIFO head in place; the record leaves the FIFO only at its final-byte handshake.
- tx_data and tx_valid are registered.
  - A handshake occurs when tx_valid & tx_ready.
  - While tx_valid & !tx_ready, tx_data is held stable and tx_valid stays high.
- Latency:
  - A record pushed into an empty FIFO in cycle N has HDR with tx_valid=1 in cycle N+2.
  - With tx_ready tied high, frames are back-to-back with no idle cycle between them.
- Reset mid-frame: next cycle tx_valid=0, the partial frame is abandoned, and the FIFO and counters are cleared. No resumption.
- Drop flag: reported in the HDR of the first record accepted after one or more drops, then cleared.
- addr with we=0 is not transmitted. addr=0 with we=1 is transmitted as-is.

Decomposition:
- Shared package yarvi_trace_pkg:
  - sync nibble 4'hA
  - HDR bit positions (we=3, drop=2, prv=1:0)
  - FSM state encoding
  - record field offsets and record width of 105
- Sub-module yarvi_sync_fifo (parameters WIDTH, DEPTH):
  - registered count; full/empty outputs
  - combinational head read; push/pop same cycle allowed
  - synchronous active-high reset

Test Plan:
- No writeback, tx_ready=1: valid with prv=3, pc=0x80000000, insn=0x00000013, we=0 -> bytes A3 00 00 00 80 13 00 00 00, tx_valid first high 2 cycles after push.
- Writeback: prv=3, pc=0x80000004, insn=0x00500293, we=1, addr=5, d=0x12345678 -> AB 04 00 00 80 93 02 50 00 05 78 56 34 12.
- Backpressure: previous record with tx_ready toggled 1,0,0,1 per cycle -> identical byte sequence; tx_data stable across stalled cycles; no byte duplicated or skipped.
- Overflow:
  - DEPTH=4, tx_ready=0, six consecutive commits -> 4 accepted, dropped_count=2, overflow=1.
  - Raise tx_ready, drain, then push a prv=3 we=0 record -> its HDR is 0xA7.
  - Push another -> its HDR is 0xA3.
- Back-to-back: three we=0 records in consecutive cycles, tx_ready=1 -> 27 contiguous valid bytes, three 0xA? headers at byte offsets 0, 9, 18.
- Reset mid-frame: assert reset after PC1 handshake of a 14-byte frame -> tx_valid=0 next cycle, overflow=0, dropped_count=0; next commit produces a fresh HDR.

Source files
------------

// File: rtl/yarvi_trace_pkg.sv
// ----------------------------------------------------------------------------
// yarvi_trace_pkg
// Shared definitions for the retired-instruction trace producer:
//   - frame sync nibble and header bit positions
//   - serializer FSM state encoding
//   - commit record layout (105 bits) and its field offsets
//   - rec_byte(): selects the stream byte for a given record / state / index
// No ports (package).
// ----------------------------------------------------------------------------
package yarvi_trace_pkg;

    // Upper nibble of every frame header, lets a receiver resynchronise.
    localparam logic [3:0] SYNC_NIBBLE = 4'hA;

    // Header byte layout: {SYNC_NIBBLE, we, drop, prv[1:0]}
    localparam int HDR_WE_BIT   = 3;
    localparam int HDR_DROP_BIT = 2;
    localparam int HDR_PRV_MSB  = 1;
    localparam int HDR_PRV_LSB  = 0;

    // Serializer FSM encoding
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_HDR  = 3'd1;
    localparam logic [2:0] ST_PC   = 3'd2;
    localparam logic [2:0] ST_INSN = 3'd3;
    localparam logic [2:0] ST_RD   = 3'd4;
    localparam logic [2:0] ST_DATA = 3'd5;

    // Record layout, MSB first: {drop, prv, pc, insn, we, addr, d}
    localparam int REC_W        = 105;
    localparam int REC_D_LSB    = 0;
    localparam int REC_ADDR_LSB = 32;
    localparam int REC_WE_BIT   = 37;
    localparam int REC_INSN_LSB = 38;
    localparam int REC_PC_LSB   = 70;
    localparam int REC_PRV_LSB  = 102;
    localparam int REC_DROP_BIT = 104;

    typedef struct packed {
        logic        drop;
        logic [1:0]  prv;
        logic [31:0] pc;
        logic [31:0] insn;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] d;
    } trace_rec_t;

    // Byte presented on the stream while the FSM sits in state st with
    // byte counter idx (multi-byte fields are sent LSB first).
    function automatic logic [7:0] rec_byte(input trace_rec_t r,
                                            input logic [2:0] st,
                                            input logic [1:0] idx);
        logic [4:0] sh;
        logic [7:0] b;
        sh = {idx, 3'b000};
        b  = 8'h00;
        case (st)
            ST_HDR: begin
                b[7:4]                       = SYNC_NIBBLE;
                b[HDR_WE_BIT]                = r.we;
                b[HDR_DROP_BIT]              = r.drop;
                b[HDR_PRV_MSB:HDR_PRV_LSB]   = r.prv;
            end
            ST_PC:   b = r.pc[sh +: 8];
            ST_INSN: b = r.insn[sh +: 8];
            ST_RD:   b = {3'b000, r.addr};
            ST_DATA: b = r.d[sh +: 8];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/yarvi_sync_fifo.sv
// ----------------------------------------------------------------------------
// yarvi_sync_fifo
// Single-clock FIFO with registered occupancy and combinational head read.
// Push and pop in the same cycle are allowed; push while full and pop while
// empty are ignored.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_push, i_data    write request and data
//   i_pop             remove head entry
//   o_head            current head entry (valid when !o_empty)
//   o_second          entry behind the head (valid when o_multi)
//   o_full, o_empty   occupancy flags from the registered count
//   o_multi           at least two entries held
// ----------------------------------------------------------------------------
module yarvi_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [WIDTH-1:0] o_second,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_multi
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    w_rd_next;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_FULL);
    assign o_empty   = (r_count == '0);
    assign o_multi   = !o_empty && (r_count != CNT_ONE);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // DEPTH is a power of two, so pointers wrap naturally.
    assign w_rd_next = r_rd_ptr + AW'(1);
    assign o_head    = r_mem[r_rd_ptr];
    assign o_second  = r_mem[w_rd_next];

    // Storage carries no reset; only pointers and count define contents.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= w_rd_next;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/yarvi_trace_tx.sv
// ----------------------------------------------------------------------------
// yarvi_trace_tx
// Producer side of the retired-instruction trace link. Commit records are
// queued in a small FIFO and serialized as framed little-endian bytes:
//   HDR, PC0..PC3, IN0..IN3 [, RD, D0..D3 when we]
// Records arriving while the FIFO is full are dropped; the next accepted
// record carries the drop flag in its header.
// Ports:
//   clock, reset          clock, synchronous active-high reset
//   valid                 commit record present this cycle
//   prv, pc, insn         privilege, pc and instruction word of the record
//   we, addr, d           optional register writeback
//   tx_data, tx_valid     registered byte stream output
//   tx_ready              sink accepts byte (handshake = tx_valid & tx_ready)
//   overflow              sticky: a record was dropped since reset
//   dropped_count         number of dropped records, saturating at 0xFFFF
// ----------------------------------------------------------------------------
module yarvi_trace_tx
    import yarvi_trace_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        valid,
    input  logic [1:0]  prv,
    input  logic [31:0] pc,
    input  logic [31:0] insn,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [31:0] d,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        overflow,
    output logic [15:0] dropped_count
);

    logic        r_drop_pending;
    logic        r_overflow;
    logic [15:0] r_dropped_cnt;
    logic [2:0]  r_state;
    logic [1:0]  r_cnt;
    logic [7:0]  r_tx_data;
    logic        r_tx_valid;

    trace_rec_t  w_in_rec;
    trace_rec_t  w_head;
    trace_rec_t  w_second;
    trace_rec_t  w_next_rec;
    logic        w_full;
    logic        w_empty;
    logic        w_multi;
    logic        w_push;
    logic        w_pop;
    logic        w_hs;
    logic        w_last;
    logic        w_more;
    logic [2:0]  w_nstate;
    logic [1:0]  w_ncnt;

    always_comb begin
        w_in_rec.drop = r_drop_pending;
        w_in_rec.prv  = prv;
        w_in_rec.pc   = pc;
        w_in_rec.insn = insn;
        w_in_rec.we   = we;
        w_in_rec.addr = addr;
        w_in_rec.d    = d;
    end

    // full comes from the registered count, so a push at full is dropped
    // even when the serializer pops in the same cycle.
    assign w_push = valid && !w_full;
    assign w_hs   = r_tx_valid && tx_ready;
    assign w_pop  = w_hs && w_last;

    yarvi_sync_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk    (clock),
        .i_rst    (reset),
        .i_push   (w_push),
        .i_data   (w_in_rec),
        .i_pop    (w_pop),
        .o_head   (w_head),
        .o_second (w_second),
        .o_full   (w_full),
        .o_empty  (w_empty),
        .o_multi  (w_multi)
    );

    // Next record after the current frame: the entry behind the head, or the
    // record being pushed this very cycle when the head is the only entry.
    // This keeps frames back-to-back without an idle cycle.
    assign w_more     = w_multi || w_push;
    assign w_next_rec = w_multi ? w_second : w_in_rec;

    // Byte sequencing within a frame; w_last marks the final byte.
    always_comb begin
        w_nstate = r_state;
        w_ncnt   = r_cnt;
        w_last   = 1'b0;
        case (r_state)
            ST_HDR: begin
                w_nstate = ST_PC;
                w_ncnt   = 2'd0;
            end
            ST_PC: begin
                if (r_cnt == 2'd3) begin
                    w_nstate = ST_INSN;
                    w_ncnt   = 2'd0;
                end else begin
                    w_ncnt = r_cnt + 2'd1;
                end
            end
            ST_INSN: begin
                if (r_cnt == 2'd3) begin
                    if (w_head.we) begin
                        w_nstate = ST_RD;
                        w_ncnt   = 2'd0;
                    end else begin
                        w_last = 1'b1;
                    end
                end else begin
                    w_ncnt = r_cnt + 2'd1;
                end
            end
            ST_RD: begin
                w_nstate = ST_DATA;
                w_ncnt   = 2'd0;
            end
            ST_DATA: begin
                if (r_cnt == 2'd3) begin
                    w_last = 1'b1;
                end else begin
                    w_ncnt = r_cnt + 2'd1;
                end
            end
            default: begin
                w_nstate = ST_IDLE;
                w_ncnt   = 2'd0;
            end
        endcase
    end

    // Serializer: output byte is registered and held until handshake.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 2'd0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'h00;
        end else if (r_state == ST_IDLE) begin
            if (!w_empty) begin
                r_state    <= ST_HDR;
                r_cnt      <= 2'd0;
                r_tx_valid <= 1'b1;
                r_tx_data  <= rec_byte(w_head, ST_HDR, 2'd0);
            end
        end else if (w_hs) begin
            if (w_last) begin
                if (w_more) begin
                    r_state    <= ST_HDR;
                    r_cnt      <= 2'd0;
                    r_tx_valid <= 1'b1;
                    r_tx_data  <= rec_byte(w_next_rec, ST_HDR, 2'd0);
                end else begin
                    r_state    <= ST_IDLE;
                    r_cnt      <= 2'd0;
                    r_tx_valid <= 1'b0;
                end
            end else begin
                r_state   <= w_nstate;
                r_cnt     <= w_ncnt;
                r_tx_data <= rec_byte(w_head, w_nstate, w_ncnt);
            end
        end
    end

    // Drop accounting; drop_pending is consumed by the next accepted record.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_drop_pending <= 1'b0;
            r_overflow     <= 1'b0;
            r_dropped_cnt  <= 16'h0000;
        end else if (valid) begin
            if (w_full) begin
                r_drop_pending <= 1'b1;
                r_overflow     <= 1'b1;
                if (r_dropped_cnt != 16'hFFFF) begin
                    r_dropped_cnt <= r_dropped_cnt + 16'h0001;
                end
            end else begin
                r_drop_pending <= 1'b0;
            end
        end
    end

    assign tx_data       = r_tx_data;
    assign tx_valid      = r_tx_valid;
    assign overflow      = r_overflow;
    assign dropped_count = r_dropped_cnt;

endmodule

// File: tb/tb_yarvi_trace_tx.sv
module tb_yarvi_trace_tx;

    logic        clock = 1'b0;
    logic        reset;
    logic        valid;
    logic [1:0]  prv;
    logic [31:0] pc;
    logic [31:0] insn;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] d;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        overflow;
    logic [15:0] dropped_count;

    always #5 clock = ~clock;

    yarvi_trace_tx #(.DEPTH(4)) dut (
        .clock         (clock),
        .reset         (reset),
        .valid         (valid),
        .prv           (prv),
        .pc            (pc),
        .insn          (insn),
        .we            (we),
        .addr          (addr),
        .d             (d),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .overflow      (overflow),
        .dropped_count (dropped_count)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rx_count = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_bytes[$];
    int         hs_cyc[$];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    logic [7:0] F_NOWB [9]  = '{8'hA3, 8'h00, 8'h00, 8'h00, 8'h80,
                                8'h13, 8'h00, 8'h00, 8'h00};
    logic [7:0] F_WB   [14] = '{8'hAB, 8'h04, 8'h00, 8'h00, 8'h80,
                                8'h93, 8'h02, 8'h50, 8'h00, 8'h05,
                                8'h78, 8'h56, 8'h34, 8'h12};
    logic       BP_PAT [4]  = '{1'b1, 1'b0, 1'b0, 1'b1};

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Stream monitor: scoreboard compare on each handshake, stall stability.
    always @(negedge clock) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(tx_valid), 32'd1);
                check("hold_data", 32'(tx_data), 32'(prev_data));
            end
            if (tx_valid && tx_ready) begin
                rx_bytes.push_back(tx_data);
                hs_cyc.push_back(cyc);
                rx_count++;
                if (exp_q.size() == 0) begin
                    n_assert++;
                    assert (exp_q.size() != 0) else begin
                        n_fail++;
                        $error("FAIL spurious_byte: observed 0x%0h expected no byte", tx_data);
                    end
                end else begin
                    check($sformatf("byte%0d", rx_count - 1), 32'(tx_data), 32'(exp_q.pop_front()));
                end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end
    end

    task automatic push_frame(input logic dr, input logic [1:0] p, input logic [31:0] pcv,
                              input logic [31:0] iv, input logic w, input logic [4:0] a,
                              input logic [31:0] dv);
        exp_q.push_back({4'hA, w, dr, p});
        for (int i = 0; i < 4; i++) exp_q.push_back(pcv[8*i +: 8]);
        for (int i = 0; i < 4; i++) exp_q.push_back(iv[8*i +: 8]);
        if (w) begin
            exp_q.push_back({3'b000, a});
            for (int i = 0; i < 4; i++) exp_q.push_back(dv[8*i +: 8]);
        end
    endtask

    task automatic commit(input logic [1:0] p, input logic [31:0] pcv, input logic [31:0] iv,
                          input logic w, input logic [4:0] a, input logic [31:0] dv);
        valid = 1'b1; prv = p; pc = pcv; insn = iv; we = w; addr = a; d = dv;
        @(posedge clock);
        #1;
        valid = 1'b0;
    endtask

    // mode 0: tx_ready held high; mode 1: tx_ready follows BP_PAT per cycle
    task automatic drain(input int mode, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clock);
            #1;
            if (mode == 1) tx_ready = BP_PAT[n % 4];
            else           tx_ready = 1'b1;
            n++;
        end
        n_assert++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL drain_timeout: observed %0d bytes outstanding expected 0", exp_q.size());
        end
        exp_q.delete();
        tx_ready = 1'b1;
        @(negedge clock);
        check("idle_after_frame", 32'(tx_valid), 32'd0);
    endtask

    initial begin
        int base;
        int hbase;
        int k;

        reset = 1'b1; valid = 1'b0; tx_ready = 1'b0;
        prv = '0; pc = '0; insn = '0; we = 1'b0; addr = '0; d = '0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'h00);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_dropped", 32'(dropped_count), 32'd0);

        // No writeback, ready high, latency check
        tx_ready = 1'b1;
        for (int i = 0; i < 9; i++) exp_q.push_back(F_NOWB[i]);
        commit(2'd3, 32'h8000_0000, 32'h0000_0013, 1'b0, 5'd0, 32'h0);
        @(negedge clock);
        check("lat_n1_valid", 32'(tx_valid), 32'd0);
        @(negedge clock);
        check("lat_n2_valid", 32'(tx_valid), 32'd1);
        check("lat_n2_hdr", 32'(tx_data), 32'hA3);
        drain(0, 40);

        // Writeback frame
        for (int i = 0; i < 14; i++) exp_q.push_back(F_WB[i]);
        commit(2'd3, 32'h8000_0004, 32'h0050_0293, 1'b1, 5'd5, 32'h1234_5678);
        drain(0, 40);

        // Same record under backpressure 1,0,0,1
        base = rx_count;
        for (int i = 0; i < 14; i++) exp_q.push_back(F_WB[i]);
        commit(2'd3, 32'h8000_0004, 32'h0050_0293, 1'b1, 5'd5, 32'h1234_5678);
        drain(1, 100);
        check("bp_byte_count", rx_count - base, 32'd14);

        // Overflow: six commits into a stalled DEPTH=4 FIFO
        tx_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) push_frame(1'b0, 2'd3, 32'h100 + 32'(4*i), 32'h13, 1'b0, 5'd0, 32'h0);
            commit(2'd3, 32'h100 + 32'(4*i), 32'h13, 1'b0, 5'd0, 32'h0);
        end
        @(negedge clock);
        check("ovf_dropped", 32'(dropped_count), 32'd2);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_hdr_waiting", 32'(tx_valid), 32'd1);
        drain(0, 200);

        base = rx_bytes.size();
        push_frame(1'b1, 2'd3, 32'h200, 32'h13, 1'b0, 5'd0, 32'h0);
        commit(2'd3, 32'h200, 32'h13, 1'b0, 5'd0, 32'h0);
        drain(0, 40);
        check("drop_hdr_a7", 32'(rx_bytes[base]), 32'hA7);
        base = rx_bytes.size();
        push_frame(1'b0, 2'd3, 32'h204, 32'h13, 1'b0, 5'd0, 32'h0);
        commit(2'd3, 32'h204, 32'h13, 1'b0, 5'd0, 32'h0);
        drain(0, 40);
        check("drop_cleared_a3", 32'(rx_bytes[base]), 32'hA3);

        // Back-to-back frames
        base  = rx_bytes.size();
        hbase = hs_cyc.size();
        for (int i = 0; i < 3; i++) begin
            push_frame(1'b0, 2'(i), 32'h300 + 32'(4*i), 32'h0000_0013 + 32'(i << 8), 1'b0, 5'd7, 32'h0);
            commit(2'(i), 32'h300 + 32'(4*i), 32'h0000_0013 + 32'(i << 8), 1'b0, 5'd7, 32'h0);
        end
        drain(0, 80);
        check("b2b_count", hs_cyc.size() - hbase, 32'd27);
        if (hs_cyc.size() - hbase == 27) begin
            check("b2b_contiguous", hs_cyc[hbase + 26] - hs_cyc[hbase], 32'd26);
            check("b2b_hdr0", 32'(rx_bytes[base][7:4]), 32'hA);
            check("b2b_hdr9", 32'(rx_bytes[base + 9][7:4]), 32'hA);
            check("b2b_hdr18", 32'(rx_bytes[base + 18][7:4]), 32'hA);
        end

        // Reset after the PC1 handshake of a 14-byte frame
        base = rx_count;
        push_frame(1'b0, 2'd3, 32'h8000_0004, 32'h0050_0293, 1'b1, 5'd5, 32'h1234_5678);
        commit(2'd3, 32'h8000_0004, 32'h0050_0293, 1'b1, 5'd5, 32'h1234_5678);
        k = 0;
        while (rx_count < base + 3 && k < 50) begin
            @(posedge clock);
            #1;
            k++;
        end
        check("rst_mid_reached_pc1", rx_count - base, 32'd3);
        reset = 1'b1;
        tx_ready = 1'b0;
        exp_q.delete();
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("rst_mid_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_mid_overflow", 32'(overflow), 32'd0);
        check("rst_mid_dropped", 32'(dropped_count), 32'd0);
        check("rst_mid_no_extra", rx_count - base, 32'd3);
        tx_ready = 1'b1;
        base = rx_bytes.size();
        push_frame(1'b0, 2'd1, 32'h400, 32'h13, 1'b0, 5'd0, 32'h0);
        commit(2'd1, 32'h400, 32'h13, 1'b0, 5'd0, 32'h0);
        drain(0, 40);
        check("rst_fresh_hdr", 32'(rx_bytes[base]), 32'hA1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no completion expected end of test");
        $fatal(1);
    end

endmodule
